snake_stream: RTL

SNAKE_STREAM -- requirements
Module: snake_stream

---
 rtl/snake_stream_pkg.sv | 10 +
 rtl/snake_step.sv | 17 +
 rtl/snake_stream.sv | 128 ++++++++++++
 3 files changed

// File: rtl/snake_stream_pkg.sv
// snake_stream_pkg: playfield size, direction encoding and helpers shared by the snake stream.
package snake_stream_pkg;
    localparam int GAME_WIDTH  = 20;
    localparam int GAME_HEIGHT = 14;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic {ST_STREAM, ST_UPDATE} state_t;
    function automatic dir_t opposite(input dir_t d);
        return dir_t'({d[1], ~d[0]});
    endfunction
endpackage

// File: rtl/snake_step.sv
// snake_step: moves a field coordinate one cell in a direction and flags leaving the field.
module snake_step
    import snake_stream_pkg::*;
(
    input  logic [4:0] i_x,
    input  logic [3:0] i_y,
    input  dir_t       i_dir,
    output logic [4:0] o_x,
    output logic [3:0] o_y,
    output logic       o_oob
);
    always_comb begin
        o_x   = (i_dir == DIR_LEFT) ? i_x - 5'd1 : (i_dir == DIR_RIGHT) ? i_x + 5'd1 : i_x;
        o_y   = (i_dir == DIR_UP) ? i_y - 4'd1 : (i_dir == DIR_DOWN) ? i_y + 4'd1 : i_y;
        o_oob = (o_x == 5'd0) || (o_x > 5'(GAME_WIDTH)) || (o_y == 4'd0) || (o_y > 4'(GAME_HEIGHT));
    end
endmodule

// File: rtl/snake_stream.sv
// snake_stream: snake body kept as a ring of directions, streamed head to tail each pass,
// with one pending move applied in the single UPDATE cycle between passes.
module snake_stream
    import snake_stream_pkg::*;
#(
    parameter int MAX_LEN   = 64,
    parameter int START_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_restart,
    input  logic       move_valid,
    input  logic [1:0] move_dir,
    input  logic       grow,
    output logic       move_busy,
    output logic       wall_hit,
    output logic       self_hit,
    output logic       full,
    output logic [4:0] snake_head_x,
    output logic [3:0] snake_head_y,
    output logic [4:0] snake_x,
    output logic [3:0] snake_y,
    output logic [1:0] snake_dir,
    output logic       snake_first,
    output logic       snake_last,
    output logic       snake_valid
);
    localparam int PW = $clog2(MAX_LEN);
    localparam logic [PW:0] LEN_MAX   = (PW + 1)'(MAX_LEN);
    localparam logic [PW:0] LEN_START = (PW + 1)'(START_LEN);
    localparam logic [4:0]  X0 = 5'(GAME_WIDTH / 2);
    localparam logic [3:0]  Y0 = 4'(GAME_HEIGHT / 2);
    localparam logic [MAX_LEN-1:0][1:0] RING0 = {MAX_LEN{2'b10}};

    state_t r_state, w_next;
    logic [MAX_LEN-1:0][1:0] r_ring;
    logic [PW-1:0] r_hp, r_seg, w_idx;
    logic [PW:0] r_len;
    logic [4:0] r_hx, r_cx, r_ox, w_ix, w_sx;
    logic [3:0] r_hy, r_cy, r_oy, w_iy, w_sy;
    dir_t r_odir, r_pdir, w_cdir, w_tdir, w_sdir;
    logic r_pend, r_pgrow, r_chk, r_hit, r_valid, r_first, r_last, r_wall, r_self;
    logic w_last, w_oob, w_upd;

    assign w_upd  = (r_state == ST_UPDATE);
    assign w_idx  = r_hp + r_seg;
    assign w_cdir = dir_t'(r_ring[w_idx]);
    assign w_last = ({1'b0, r_seg} == r_len - 1'b1);
    // A request pointing back into the neck keeps the current heading instead.
    assign w_tdir = (r_pdir == r_ring[r_hp]) ? opposite(r_pdir) : r_pdir;
    // One stepper: walks the cursor while streaming, moves the head during UPDATE.
    assign w_ix   = w_upd ? r_hx : r_cx;
    assign w_iy   = w_upd ? r_hy : r_cy;
    assign w_sdir = w_upd ? w_tdir : w_cdir;

    snake_step u_step (
        .i_x  (w_ix),
        .i_y  (w_iy),
        .i_dir(w_sdir),
        .o_x  (w_sx),
        .o_y  (w_sy),
        .o_oob(w_oob)
    );

    always_comb begin
        w_next = (w_upd || !w_last) ? ST_STREAM : ST_UPDATE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_STREAM;
        else     r_state <= game_restart ? ST_STREAM : w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ring <= RING0;
            {r_hp, r_seg} <= '0;
            r_len <= LEN_START;
            {r_hx, r_hy, r_cx, r_cy} <= {X0, Y0, X0, Y0};
            {r_ox, r_oy} <= '0;
            {r_odir, r_pdir} <= {DIR_UP, DIR_UP};
            {r_pend, r_pgrow, r_chk, r_hit, r_valid, r_first, r_last, r_wall, r_self} <= '0;
        end else if (game_restart) begin
            r_ring <= RING0;
            {r_hp, r_seg} <= '0;
            r_len <= LEN_START;
            {r_hx, r_hy, r_cx, r_cy} <= {X0, Y0, X0, Y0};
            {r_ox, r_oy} <= '0;
            {r_odir, r_pdir} <= {DIR_UP, DIR_UP};
            {r_pend, r_pgrow, r_chk, r_hit, r_valid, r_first, r_last, r_wall, r_self} <= '0;
        end else begin
            {r_valid, r_first, r_last, r_wall, r_self} <= '0;
            if (!w_upd) begin
                {r_valid, r_first, r_last} <= {1'b1, r_seg == '0, w_last};
                {r_ox, r_oy, r_odir} <= {r_cx, r_cy, w_cdir};
                {r_cx, r_cy} <= {w_sx, w_sy};
                r_seg <= r_seg + 1'b1;
                if (r_chk && r_seg != '0 && r_cx == r_hx && r_cy == r_hy) r_hit <= 1'b1;
            end else begin
                r_seg <= '0;
                {r_self, r_hit, r_chk, r_pend} <= {r_hit, 3'b000};
                {r_cx, r_cy} <= {r_hx, r_hy};
                if (r_pend && w_oob) r_wall <= 1'b1;
                if (r_pend && !w_oob) begin
                    r_hp <= r_hp - 1'b1;
                    r_ring[r_hp - 1'b1] <= opposite(w_tdir);
                    {r_hx, r_hy, r_cx, r_cy} <= {w_sx, w_sy, w_sx, w_sy};
                    r_chk <= 1'b1;
                    if (r_pgrow && r_len != LEN_MAX) r_len <= r_len + 1'b1;
                end
            end
            if (move_valid) {r_pend, r_pdir, r_pgrow} <= {1'b1, dir_t'(move_dir), grow};
        end
    end

    assign move_busy    = r_pend;
    assign wall_hit     = r_wall;
    assign self_hit     = r_self;
    assign full         = (r_len == LEN_MAX);
    assign snake_head_x = r_hx;
    assign snake_head_y = r_hy;
    assign snake_x      = r_ox;
    assign snake_y      = r_oy;
    assign snake_dir    = r_odir;
    assign snake_first  = r_first;
    assign snake_last   = r_last;
    assign snake_valid  = r_valid;
endmodule
